// File: rtl/seizure_classifier_seq.sv
// Purpose: weighted feature-flag classifier, one channel per cycle, with on/off hysteresis on the decision.
// Latency: window accepted at cycle T -> win_valid/sum_out/seizure updated at T+NUM_CH+1; one window per NUM_CH+2 cycles.
// Backpressure: feat_ready is low from accept until the decision is issued; weight writes while busy are dropped with wr_err.
module seizure_classifier_seq #(
  parameter int NUM_CH    = 16,
  parameter int NUM_FEAT  = 6,
  parameter int W_WIDTH   = 12,
  parameter int SUM_WIDTH = 20,
  parameter int ON_COUNT  = 2,
  parameter int OFF_COUNT = 3,
  localparam int AW = $clog2(NUM_CH*NUM_FEAT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        feat_valid,
  output logic                        feat_ready,
  input  logic [NUM_CH*NUM_FEAT-1:0]  feat_bits,
  input  logic signed [SUM_WIDTH-1:0] threshold,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic signed [W_WIDTH-1:0]   wr_data,
  output logic                        wr_err,
  output logic signed [SUM_WIDTH-1:0] sum_out,
  output logic                        win_valid,
  output logic                        seizure
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Exact width of one channel's partial sum (NUM_FEAT signed weights added together)
  localparam int PW  = W_WIDTH + $clog2(NUM_FEAT);
  localparam int CW  = $clog2(((ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT) + 1);

  localparam logic signed [SUM_WIDTH-1:0] SMAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SMIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;

  logic [1:0]                  state;
  logic [CHW-1:0]              ch;
  logic signed [SUM_WIDTH-1:0] acc;
  logic signed [SUM_WIDTH-1:0] acc_nxt;
  logic signed [SUM_WIDTH-1:0] thr_q;
  logic [NUM_FEAT-1:0]         fq   [NUM_CH];
  logic signed [W_WIDTH-1:0]   wmem [NUM_CH][NUM_FEAT];
  logic signed [PW-1:0]        part;
  logic signed [SUM_WIDTH:0]   wide;
  logic [CW-1:0]               on_cnt;
  logic [CW-1:0]               off_cnt;
  logic                        accept;
  logic                        wr_ok;
  logic                        hit;
  logic                        last_ch;

  assign feat_ready = (state == S_IDLE);
  assign accept     = feat_valid && feat_ready;
  assign wr_ok      = (state == S_IDLE) && (int'(wr_addr) < NUM_CH*NUM_FEAT);
  assign last_ch    = (ch == CHW'(NUM_CH-1));
  assign hit        = (acc >= thr_q);

  // Weight table: writes land only while idle (a write in the accept cycle is seen by that window)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int f = 0; f < NUM_FEAT; f++)
          wmem[c][f] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_en && wr_ok) begin
        for (int c = 0; c < NUM_CH; c++)
          for (int f = 0; f < NUM_FEAT; f++)
            if (wr_addr == AW'(c*NUM_FEAT + f))
              wmem[c][f] <= wr_data;
      end
    end
  end

  // Current channel's exact partial sum, then saturating add into the accumulator
  always_comb begin
    part = '0;
    for (int f = 0; f < NUM_FEAT; f++)
      if (fq[ch][f])
        part = part + PW'(wmem[ch][f]);
    wide = (SUM_WIDTH+1)'(acc) + (SUM_WIDTH+1)'(part);
    if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1])
      acc_nxt = wide[SUM_WIDTH] ? SMIN : SMAX;
    else
      acc_nxt = wide[SUM_WIDTH-1:0];
  end

  // Window sequencer: latch inputs, walk the channels, publish the sum
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ch        <= '0;
      acc       <= '0;
      thr_q     <= '0;
      sum_out   <= '0;
      win_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        fq[c] <= '0;
    end else begin
      win_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int c = 0; c < NUM_CH; c++)
              fq[c] <= feat_bits[c*NUM_FEAT +: NUM_FEAT];
            thr_q <= threshold;
            acc   <= '0;
            ch    <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc_nxt;
          ch  <= ch + CHW'(1);
          if (last_ch)
            state <= S_DECIDE;
        end
        S_DECIDE: begin
          sum_out   <= acc;
          win_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Hysteresis: a run of windows disagreeing with the current level flips it
  always_ff @(posedge clk) begin
    if (reset) begin
      seizure <= 1'b0;
      on_cnt  <= '0;
      off_cnt <= '0;
    end else if (state == S_DECIDE) begin
      if (!seizure) begin
        off_cnt <= '0;
        if (!hit) begin
          on_cnt <= '0;
        end else if (on_cnt == CW'(ON_COUNT-1)) begin
          seizure <= 1'b1;
          on_cnt  <= '0;
        end else begin
          on_cnt <= on_cnt + CW'(1);
        end
      end else begin
        on_cnt <= '0;
        if (hit) begin
          off_cnt <= '0;
        end else if (off_cnt == CW'(OFF_COUNT-1)) begin
          seizure <= 1'b0;
          off_cnt <= '0;
        end else begin
          off_cnt <= off_cnt + CW'(1);
        end
      end
    end
  end

endmodule
